mdu_sequencer: RTL and testbench

//  Multi-cycle sequencer for the MULT and DIV ALU operations, which cannot complete in one cycle.
//  - Accepts the 3-bit ALU operation select produced by ALU control:
//    3'b010 = MULT, 3'b011 = DIV. All other codes are not handled here.
//  - Runs an iterative shift-add multiply or a restoring divide.
//  - Stalls the pipeline while running and delivers the HI/LO results.
//  - Sits beside the main ALU in the execute stage.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_datapath.sv | 49 ++++
 rtl/mdu_sequencer.sv | 103 ++++++++++
 tb/tb_mdu_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: ALU operation codes
// and FSM state encodings.
package mdu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_MULT = 3'b010;
    localparam logic [2:0] ALU_DIV  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_AND  = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_NOP  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/mdu_datapath.sv
// Shared 2W+1-bit accumulator used both as the shift-add product register and as
// the {remainder, quotient} pair of the restoring divider.
module mdu_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             load_i,
    input  logic             step_mul_i,
    input  logic             step_div_i,
    input  logic [WIDTH-1:0] ld_lo_i,
    input  logic [WIDTH-1:0] ld_opnd_i,
    output logic [WIDTH-1:0] nxt_hi_o,
    output logic [WIDTH-1:0] nxt_lo_o,
    output logic [WIDTH-1:0] cur_lo_o
);

    logic [2*WIDTH:0] acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH:0] div_sh;
    logic [WIDTH+1:0] div_diff;

    // Low half holds the multiplier (MUL) or the dividend/quotient (DIV).
    always_comb begin
        mul_sum  = acc_q[2*WIDTH:WIDTH] + {1'b0, opnd_q};
        div_sh   = {acc_q[2*WIDTH-1:0], 1'b0};
        div_diff = {1'b0, div_sh[2*WIDTH:WIDTH]} - {2'b00, opnd_q};
        acc_d    = acc_q;
        if (load_i) begin
            acc_d = {{(WIDTH+1){1'b0}}, ld_lo_i};
        end else if (step_mul_i) begin
            if (acc_q[0]) acc_d = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
            else          acc_d = {1'b0, acc_q[2*WIDTH:1]};
        end else if (step_div_i) begin
            if (!div_diff[WIDTH+1]) acc_d = {div_diff[WIDTH:0], div_sh[WIDTH-1:1], 1'b1};
            else                    acc_d = div_sh;
        end
    end

    always_ff @(posedge clk) begin
        acc_q <= acc_d;
        if (load_i) opnd_q <= ld_opnd_i;
    end

    assign nxt_hi_o = acc_d[2*WIDTH-1:WIDTH];
    assign nxt_lo_o = acc_d[WIDTH-1:0];
    assign cur_lo_o = acc_q[WIDTH-1:0];

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/DIV sequencer beside the execute-stage ALU: stalls the pipeline
// while iterating and presents HI/LO with a one-cycle done pulse.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       IA,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, done_q, dbz_q, dbz_pend_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             is_mul, is_div, accept, last_iter;
    logic [WIDTH-1:0] nxt_hi, nxt_lo, cur_lo;

    assign is_mul    = start && (IA == ALU_MULT);
    assign is_div    = start && (IA == ALU_DIV);
    assign accept    = (is_mul || is_div) && (state_q == S_IDLE || state_q == S_DONE);
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    mdu_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk        (clk),
        .load_i     (accept),
        .step_mul_i (state_q == S_MUL),
        .step_div_i (state_q == S_DIV && !dbz_pend_q),
        .ld_lo_i    (is_mul ? op_b : op_a),
        .ld_opnd_i  (is_mul ? op_a : op_b),
        .nxt_hi_o   (nxt_hi),
        .nxt_lo_o   (nxt_lo),
        .cur_lo_o   (cur_lo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            dbz_pend_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state_q    <= is_mul ? S_MUL : S_DIV;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                        dbz_pend_q <= is_div && (op_b == '0);
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_MUL, S_DIV: begin
                    // A zero divisor skips the iterations; the dividend is still in the low half.
                    if (dbz_pend_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        hi_q    <= cur_lo;
                        lo_q    <= '1;
                        dbz_q   <= 1'b1;
                    end else if (last_iter) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        hi_q    <= nxt_hi;
                        lo_q    <= nxt_lo;
                        dbz_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign stall       = busy_q || accept;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer with hand-computed results.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  IA;
    logic [31:0] op_a, op_b;
    logic        busy, stall, done, div_by_zero;
    logic [31:0] hi, lo;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc;

    mdu_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .IA          (IA),
        .op_a        (op_a),
        .op_b        (op_b),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; IA = 3'b000; op_a = '0; op_b = '0;
        tick(); tick();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: MULT 0xFFFFFFFF * 2
        start = 1'b1; IA = 3'b010; op_a = 32'hFFFF_FFFF; op_b = 32'h2;
        #1 chk("t1_stall_pre", {31'b0, stall}, 32'd1);
        tick();
        start = 1'b0;
        #1 chk("t1_busy_e0", {31'b0, busy}, 32'd1);
        for (int k = 1; k <= 31; k++) tick();
        chk("t1_stall_e31", {31'b0, stall}, 32'd1);
        chk("t1_done_e31", {31'b0, done}, 32'd0);
        tick();
        chk("t1_done_e32", {31'b0, done}, 32'd1);
        chk("t1_hi", hi, 32'h0000_0001);
        chk("t1_lo", lo, 32'hFFFF_FFFE);
        chk("t1_stall_done", {31'b0, stall}, 32'd0);
        tick();
        chk("t1_done_pulse", {31'b0, done}, 32'd0);
        chk("t1_hi_hold", hi, 32'h0000_0001);

        // 2: DIV 100 / 7
        start = 1'b1; IA = 3'b011; op_a = 32'd100; op_b = 32'd7;
        tick();
        start = 1'b0;
        wait_done(cyc);
        chk("t2_latency", cyc, 32'd32);
        chk("t2_lo", lo, 32'd14);
        chk("t2_hi", hi, 32'd2);
        chk("t2_dbz", {31'b0, div_by_zero}, 32'd0);
        tick();
        chk("t2_done_pulse", {31'b0, done}, 32'd0);

        // 3: DIV by zero
        start = 1'b1; IA = 3'b011; op_a = 32'h1234; op_b = 32'd0;
        tick();
        start = 1'b0;
        wait_done(cyc);
        chk("t3_latency", cyc, 32'd1);
        chk("t3_lo", lo, 32'hFFFF_FFFF);
        chk("t3_hi", hi, 32'h0000_1234);
        chk("t3_dbz", {31'b0, div_by_zero}, 32'd1);
        tick();

        // 4: back-to-back MULT 3*4 then DIV 9/2
        start = 1'b1; IA = 3'b010; op_a = 32'd3; op_b = 32'd4;
        tick();
        wait_done(cyc);
        chk("t4_lat1", cyc, 32'd32);
        chk("t4_hi1", hi, 32'd0);
        chk("t4_lo1", lo, 32'd12);
        IA = 3'b011; op_a = 32'd9; op_b = 32'd2;
        #1 chk("t4_stall_done", {31'b0, stall}, 32'd1);
        tick();
        start = 1'b0;
        chk("t4_busy_b2b", {31'b0, busy}, 32'd1);
        chk("t4_lo_hold", lo, 32'd12);
        wait_done(cyc);
        chk("t4_lat2", cyc, 32'd32);
        chk("t4_lo2", lo, 32'd4);
        chk("t4_hi2", hi, 32'd1);
        tick();

        // 5: ignored requests
        start = 1'b1; IA = 3'b000; op_a = 32'd5; op_b = 32'd6;
        #1 chk("t5_stall_add", {31'b0, stall}, 32'd0);
        tick();
        chk("t5_busy_add", {31'b0, busy}, 32'd0);
        IA = 3'b010;
        tick();
        IA = 3'b010; op_a = 32'd7; op_b = 32'd7;
        wait_done(cyc);
        start = 1'b0;
        chk("t5_lat", cyc, 32'd32);
        chk("t5_lo", lo, 32'd30);
        chk("t5_hi", hi, 32'd0);
        tick();

        // 6: reset during DIV, then fresh MULT
        start = 1'b1; IA = 3'b011; op_a = 32'd1000; op_b = 32'd3;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        rst_n = 1'b0;
        tick();
        chk("t6_busy", {31'b0, busy}, 32'd0);
        chk("t6_done", {31'b0, done}, 32'd0);
        chk("t6_hi", hi, 32'd0);
        chk("t6_lo", lo, 32'd0);
        chk("t6_stall", {31'b0, stall}, 32'd0);
        rst_n = 1'b1;
        tick();
        start = 1'b1; IA = 3'b010; op_a = 32'h0001_0000; op_b = 32'h0001_0001;
        tick();
        start = 1'b0;
        wait_done(cyc);
        chk("t6_lat", cyc, 32'd32);
        chk("t6_mhi", hi, 32'h0000_0001);
        chk("t6_mlo", lo, 32'h0001_0000);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
